ad_ip_jesd204_tpl_dac_source_mux: RTL and testbench
===================================================

# ad_ip_jesd204_tpl_dac_source_mux

Per-channel data-source selector for the JESD204 DAC transport layer. It takes the register-controlled source select, pattern words and DDS samples, and produces one beat of DATA_PATH_WIDTH 16-bit samples per link clock. It runs the pattern, ramp and PN generators locally and handshakes the DMA stream. It sits between the regmap/DDS outputs and the framer input, with one instance per converter channel.

## Interface
- DATA_PATH_WIDTH, 4, samples per beat (1..16)
- link_clk  in  1  link clock; all logic on rising edge
- dac_rst  in  1  reset, asynchronous, active-high
- dac_data_sel  in  4  source select, quasi-static, already in link_clk domain
- dac_pat_data_0  in  16  pattern word for even samples
- dac_pat_data_1  in  16  pattern word for odd samples
- dds_data  in  16*DATA_PATH_WIDTH  DDS samples, sample 0 in LSBs
- dma_data  in  16*DATA_PATH_WIDTH  DMA samples, sample 0 in LSBs
- dma_valid  in  1  dma_data valid this cycle
- dma_ready  out  1  beat consumed this cycle
- dac_data  out  16*DATA_PATH_WIDTH  selected beat to framer, sample 0 in LSBs
- dac_dunf  out  1  DMA underflow flag, one pulse per starved beat

## Operation
- Select codes: 0 DDS, 1 pattern, 2 DMA, 3 zero, 6 PN7, 7 PN15, 11 ramp. Every other code outputs zeros.
- DDS: dds_data is registered straight through.
- Pattern: sample k = dac_pat_data_0 for even k, dac_pat_data_1 for odd k. The pattern is stateless per beat.
- Ramp: sample k = base + k (mod 2^16). base advances by DATA_PATH_WIDTH every cycle and wraps at 16 bits.
- PN7 uses x^7+x^6+1. PN15 uses x^15+x^14+1.
  - Each LFSR state is seeded all-ones and advances 16*DATA_PATH_WIDTH bits per cycle.
  - Sample 0 takes the first 16 generated bits, first bit in the MSB.
  - Only the selected LFSR advances.
- DMA:
  - dma_ready = 1 whenever select == 2 and not in reset; otherwise 0.
  - The beat transfers when dma_valid && dma_ready.
  - In DMA mode with dma_valid = 0, the beat outputs zeros and dac_dunf = 1 for that beat.
- Mode entry: a change of dac_data_sel resets base to 0 and reseeds both LFSRs to all-ones, so every entry into a generator mode restarts the sequence from its first sample.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on dac_data and dac_dunf after edge N. dma_ready is combinational from the registered select (see below).
- Select change:
  - dac_data_sel is registered internally (sel_q).
  - A mismatch between dac_data_sel and sel_q at edge N triggers the generator restart at edge N.
  - The first beat of the new mode appears after edge N+1.
  - During the one transition beat dac_data = 0.
- dma_ready follows sel_q, so it asserts one cycle after the select changes to DMA.
- Reset values: dac_data = 0, dac_dunf = 0, dma_ready = 0, sel_q = 3 (zero), base = 0, LFSRs all-ones.
- Reset mid-operation: all outputs clear asynchronously. Generators restart from seed after release. A DMA beat presented during reset is not consumed.
- Ramp wrap: with DATA_PATH_WIDTH = 4 and base = 0xFFFE, the beat is FFFE, FFFF, 0000, 0001.
- Select held during a DMA underflow: dac_dunf repeats every starved cycle with no hold-off.

## Configuration
- AD_IP_JESD204_TPL_DAC_PN_EN
  - Defined: PN7/PN15 generators are built as described.
  - Undefined: no LFSR logic is built and codes 6/7 behave as unsupported codes (zero output).

## Structure
- Shared package ad_ip_jesd204_tpl_dac_pkg holds:
  - select-code constants (SEL_DDS, SEL_PAT, SEL_DMA, SEL_ZERO, SEL_PN7, SEL_PN15, SEL_RAMP);
  - PN polynomial tap constants;
  - the seed value.
- One sub-module: ad_ip_jesd204_tpl_dac_pn_gen, a parallel-output LFSR parameterised by length, taps and output width, with a reseed input. It is instantiated twice (PN7, PN15) under the macro.

## Test plan
- Reset and zero mode:
  - Assert dac_rst mid-stream -> dac_data = 0, dma_ready = 0, dac_dunf = 0 immediately.
  - After release with sel = 3 -> all-zero beats.
- Pattern:
  - Stimulus: sel = 1, pat_0 = 0x1234, pat_1 = 0xABCD, DATA_PATH_WIDTH = 4.
  - Required response: from the second beat after the select change, every beat is 1234, ABCD, 1234, ABCD.
- Ramp:
  - Stimulus: sel = 11.
  - Required response: first beat 0, 1, 2, 3; next beat 4..7; sample 0x10000 wraps to 0x0000.
  - Reselect 11 after sel = 3 -> ramp restarts at 0.
- PN:
  - Stimulus: sel = 6, then sel = 7.
  - Required response: output bitstreams match a bit-serial model from the all-ones seed, periods 127 and 32767 bits.
  - With AD_IP_JESD204_TPL_DAC_PN_EN undefined -> zeros.
- DMA:
  - Stimulus: sel = 2, dma_valid toggling 1,1,0,1 with data 0x0001.., 0x0005.., x, 0x0009...
  - Required response: output beats equal the data for the valid beats; the third beat is zeros with dac_dunf = 1 for exactly one cycle.
  - dma_ready = 0 in all other modes.
- DDS passthrough and invalid code:
  - Stimulus: sel = 0 with an incrementing dds_data.
  - Required response: dds_data delayed by exactly one cycle.
  - sel = 5 -> zeros.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared constants for the JESD204 DAC transport-layer source mux:
// select codes, PN polynomial taps and LFSR seeds.
package ad_ip_jesd204_tpl_dac_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SEL_W    = 4;

  localparam logic [SEL_W-1:0] SEL_DDS  = 4'd0;
  localparam logic [SEL_W-1:0] SEL_PAT  = 4'd1;
  localparam logic [SEL_W-1:0] SEL_DMA  = 4'd2;
  localparam logic [SEL_W-1:0] SEL_ZERO = 4'd3;
  localparam logic [SEL_W-1:0] SEL_PN7  = 4'd6;
  localparam logic [SEL_W-1:0] SEL_PN15 = 4'd7;
  localparam logic [SEL_W-1:0] SEL_RAMP = 4'd11;

  // Fibonacci taps: x^7+x^6+1 and x^15+x^14+1, MSB of the state is x^LEN
  localparam int unsigned PN7_LEN  = 7;
  localparam int unsigned PN15_LEN = 15;
  localparam logic [PN7_LEN-1:0]  PN7_TAPS  = 7'h60;
  localparam logic [PN15_LEN-1:0] PN15_TAPS = 15'h6000;
  localparam logic [PN7_LEN-1:0]  PN7_SEED  = 7'h7f;
  localparam logic [PN15_LEN-1:0] PN15_SEED = 15'h7fff;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_pn_gen.sv
// Parallel-output Fibonacci LFSR: emits OUT_W bits per advance, first bit in
// the MSB of each 16-bit sample, sample 0 in the LSBs. Built only under
// AD_IP_JESD204_TPL_DAC_PN_EN by the source mux.
module ad_ip_jesd204_tpl_dac_pn_gen #(
  parameter int unsigned      LEN   = 7,
  parameter logic [LEN-1:0]   TAPS  = 7'h60,
  parameter logic [LEN-1:0]   SEED  = '1,
  parameter int unsigned      OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             reseed,
  output logic [OUT_W-1:0] data_c
);

  localparam int unsigned WORD_W = 16;

  logic [LEN-1:0]    state;
  logic [LEN-1:0]    state_next;
  logic [WORD_W-1:0] word;
  logic              fb;

  // Unroll OUT_W serial steps from the current state
  always_comb begin
    state_next = state;
    data_c     = '0;
    word       = '0;
    fb         = 1'b0;
    for (int unsigned j = 0; j < OUT_W / WORD_W; j++) begin
      for (int unsigned b = 0; b < WORD_W; b++) begin
        fb         = ^(state_next & TAPS);
        word       = {word[WORD_W-2:0], fb};
        state_next = {state_next[LEN-2:0], fb};
      end
      data_c[WORD_W*j +: WORD_W] = word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (reseed) begin
      state <= SEED;
    end else if (advance) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_source_mux.sv
// Per-channel DAC data-source selector: DDS, pattern, DMA, zero, ramp and,
// when AD_IP_JESD204_TPL_DAC_PN_EN is defined, PN7/PN15 generators.
module ad_ip_jesd204_tpl_dac_source_mux
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int unsigned DATA_PATH_WIDTH = 4
) (
  input  logic                                link_clk,
  input  logic                                dac_rst,
  input  logic [SEL_W-1:0]                    dac_data_sel,
  input  logic [SAMPLE_W-1:0]                 dac_pat_data_0,
  input  logic [SAMPLE_W-1:0]                 dac_pat_data_1,
  input  logic [SAMPLE_W*DATA_PATH_WIDTH-1:0] dds_data,
  input  logic [SAMPLE_W*DATA_PATH_WIDTH-1:0] dma_data,
  input  logic                                dma_valid,
  output logic                                dma_ready,
  output logic [SAMPLE_W*DATA_PATH_WIDTH-1:0] dac_data,
  output logic                                dac_dunf
);

  localparam int unsigned BEAT_W = SAMPLE_W * DATA_PATH_WIDTH;

  logic [SEL_W-1:0]    sel_q;
  logic [SAMPLE_W-1:0] base;
  logic                sel_change;
  logic [BEAT_W-1:0]   beat_c;
  logic                dunf_c;

  assign sel_change = (dac_data_sel != sel_q);
  assign dma_ready  = (sel_q == SEL_DMA) && !dac_rst;

`ifdef AD_IP_JESD204_TPL_DAC_PN_EN
  logic [BEAT_W-1:0] pn7_data;
  logic [BEAT_W-1:0] pn15_data;

  ad_ip_jesd204_tpl_dac_pn_gen #(
    .LEN(PN7_LEN), .TAPS(PN7_TAPS), .SEED(PN7_SEED), .OUT_W(BEAT_W)
  ) i_pn7 (
    .clk(link_clk), .rst(dac_rst),
    .advance(!sel_change && (sel_q == SEL_PN7)),
    .reseed(sel_change), .data_c(pn7_data)
  );

  ad_ip_jesd204_tpl_dac_pn_gen #(
    .LEN(PN15_LEN), .TAPS(PN15_TAPS), .SEED(PN15_SEED), .OUT_W(BEAT_W)
  ) i_pn15 (
    .clk(link_clk), .rst(dac_rst),
    .advance(!sel_change && (sel_q == SEL_PN15)),
    .reseed(sel_change), .data_c(pn15_data)
  );
`endif

  // Beat selection; a select change forces one all-zero transition beat
  always_comb begin
    beat_c = '0;
    dunf_c = 1'b0;
    if (!sel_change) begin
      case (sel_q)
        SEL_DDS: beat_c = dds_data;
        SEL_PAT: begin
          for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
            beat_c[SAMPLE_W*k +: SAMPLE_W] = (k % 2 == 0) ? dac_pat_data_0 : dac_pat_data_1;
          end
        end
        SEL_DMA: begin
          if (dma_valid) begin
            beat_c = dma_data;
          end else begin
            dunf_c = 1'b1;
          end
        end
        SEL_RAMP: begin
          for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
            beat_c[SAMPLE_W*k +: SAMPLE_W] = base + SAMPLE_W'(k);
          end
        end
`ifdef AD_IP_JESD204_TPL_DAC_PN_EN
        SEL_PN7:  beat_c = pn7_data;
        SEL_PN15: beat_c = pn15_data;
`endif
        default: beat_c = '0;
      endcase
    end
  end

  always_ff @(posedge link_clk or posedge dac_rst) begin
    if (dac_rst) begin
      sel_q    <= SEL_ZERO;
      base     <= '0;
      dac_data <= '0;
      dac_dunf <= 1'b0;
    end else begin
      sel_q    <= dac_data_sel;
      dac_data <= beat_c;
      dac_dunf <= dunf_c;
      base     <= sel_change ? '0 : base + SAMPLE_W'(DATA_PATH_WIDTH);
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_source_mux.sv
// Randomized self-checking bench for ad_ip_jesd204_tpl_dac_source_mux against
// a beat-level reference model (mode epoch counter + serial PN sequences).
module tb_ad_ip_jesd204_tpl_dac_source_mux;

  localparam int unsigned DPW = 4;
  localparam int unsigned BW  = 16 * DPW;

`ifdef AD_IP_JESD204_TPL_DAC_PN_EN
  localparam bit PN_EN = 1'b1;
`else
  localparam bit PN_EN = 1'b0;
`endif

  logic          link_clk = 1'b0;
  logic          dac_rst  = 1'b1;
  logic [3:0]    dac_data_sel = 4'd3;
  logic [15:0]   pat0 = '0;
  logic [15:0]   pat1 = '0;
  logic [BW-1:0] dds  = '0;
  logic [BW-1:0] dma  = '0;
  logic          dma_valid = 1'b0;
  logic          dma_ready;
  logic [BW-1:0] dac_data;
  logic          dac_dunf;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: active select and beats produced since mode entry
  int m_sel = 3;
  int m_n   = 0;
  bit pn7_seq  [127];
  bit pn15_seq [32767];

  logic [BW-1:0] ed;
  logic          eu;
  logic          er;

  ad_ip_jesd204_tpl_dac_source_mux #(.DATA_PATH_WIDTH(DPW)) dut (
    .link_clk(link_clk), .dac_rst(dac_rst), .dac_data_sel(dac_data_sel),
    .dac_pat_data_0(pat0), .dac_pat_data_1(pat1), .dds_data(dds),
    .dma_data(dma), .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dac_data(dac_data), .dac_dunf(dac_dunf)
  );

  always #5 link_clk = ~link_clk;

  function automatic logic [BW-1:0] expect_gen(int mode, int n);
    logic [BW-1:0] r;
    logic [15:0]   s;
    int            idx;
    r = '0;
    for (int k = 0; k < int'(DPW); k++) begin
      s = '0;
      case (mode)
        0:  s = dds[16*k +: 16];
        1:  s = (k % 2 == 0) ? pat0 : pat1;
        11: s = 16'((n * int'(DPW) + k) % 65536);
        6, 7: begin
          if (PN_EN) begin
            for (int b = 0; b < 16; b++) begin
              idx = n * int'(BW) + k * 16 + b;
              s[15-b] = (mode == 6) ? pn7_seq[idx % 127] : pn15_seq[idx % 32767];
            end
          end
        end
        default: s = '0;
      endcase
      r[16*k +: 16] = s;
    end
    return r;
  endfunction

  // Predict the beat for the coming edge, then advance one clock
  task automatic step(output logic [BW-1:0] e_data, output logic e_dunf, output logic e_ready);
    e_data = '0;
    e_dunf = 1'b0;
    if (!dac_rst) begin
      if (dac_data_sel != 4'(m_sel)) begin
        m_sel = int'(dac_data_sel);
        m_n   = 0;
      end else begin
        if (m_sel == 2) begin
          e_data = dma_valid ? dma : '0;
          e_dunf = !dma_valid;
        end else begin
          e_data = expect_gen(m_sel, m_n);
        end
        m_n++;
      end
    end
    @(posedge link_clk);
    @(negedge link_clk);
    e_ready = (m_sel == 2) && !dac_rst;
  endtask

  task automatic test_reset();
    @(negedge link_clk);
    vectors++;
    if (dac_data !== '0 || dac_dunf !== 1'b0 || dma_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: data=%h dunf=%b ready=%b, expected all zero", dac_data, dac_dunf, dma_ready);
    end
    dac_rst = 1'b0;
    m_sel = 3;
    m_n   = 0;
    for (int i = 0; i < 4; i++) begin
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL zero_mode: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
  endtask

  task automatic test_pattern();
    dac_data_sel = 4'd1;
    pat0 = 16'h1234;
    pat1 = 16'hABCD;
    for (int i = 0; i < 10; i++) begin
      if (i >= 5) begin
        pat0 = 16'($urandom);
        pat1 = 16'($urandom);
      end
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL pattern: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
  endtask

  task automatic test_dds();
    dac_data_sel = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) dds = {16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)};
      else       dds = {$urandom, $urandom};
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL dds: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
  endtask

  task automatic test_invalid();
    int codes [9] = '{5, 4, 8, 9, 10, 12, 13, 14, 15};
    dds  = {$urandom, $urandom};
    pat0 = 16'($urandom) | 16'h1;
    for (int c = 0; c < 9; c++) begin
      dac_data_sel = 4'(codes[c]);
      for (int i = 0; i < 2; i++) begin
        step(ed, eu, er);
        vectors++;
        if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
          miscompares++;
          $display("FAIL invalid_code %0d: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                   codes[c], dac_data, dac_dunf, dma_ready, ed, eu, er);
        end
      end
    end
  endtask

  task automatic test_ramp();
    // Run long enough to cross the 16-bit wrap, then restart after zero mode
    dac_data_sel = 4'd11;
    for (int i = 0; i < 16390; i++) begin
      if (i == 16300) dac_data_sel = 4'd3;
      if (i == 16304) dac_data_sel = 4'd11;
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL ramp beat %0d: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 i, dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
    dac_data_sel = 4'd3;
    step(ed, eu, er);
    dac_data_sel = 4'd11;
    for (int i = 0; i < 16390; i++) begin
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL ramp_wrap beat %0d: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 i, dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
  endtask

  task automatic test_pn();
    int seq [3] = '{6, 7, 6};
    int len [3] = '{12, 520, 4};
    for (int m = 0; m < 3; m++) begin
      dac_data_sel = 4'(seq[m]);
      for (int i = 0; i < len[m]; i++) begin
        step(ed, eu, er);
        vectors++;
        if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
          miscompares++;
          $display("FAIL pn%0d beat %0d: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                   (seq[m] == 6) ? 7 : 15, i, dac_data, dac_dunf, dma_ready, ed, eu, er);
        end
      end
    end
  endtask

  task automatic test_dma();
    bit            vseq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [BW-1:0] dseq [4];
    dseq[0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    dseq[1] = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    dseq[2] = {$urandom, $urandom};
    dseq[3] = {16'h000c, 16'h000b, 16'h000a, 16'h0009};
    dac_data_sel = 4'd2;
    dma_valid = 1'b1;
    dma = {$urandom, $urandom};
    for (int i = 0; i < 22; i++) begin
      if (i >= 1 && i <= 4) begin
        dma_valid = vseq[i-1];
        dma       = dseq[i-1];
      end else if (i > 4) begin
        dma_valid = 1'($urandom);
        dma       = {$urandom, $urandom};
      end
      if (i == 18) dac_data_sel = 4'd3;
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL dma beat %0d: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 i, dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
  endtask

  task automatic test_reset_mid();
    dac_data_sel = 4'd2;
    dma_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dma = {$urandom, $urandom} | 64'h1;
      step(ed, eu, er);
    end
    #2 dac_rst = 1'b1;
    #1;
    m_sel = 3;
    m_n   = 0;
    vectors++;
    if (dac_data !== '0 || dac_dunf !== 1'b0 || dma_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: data=%h dunf=%b ready=%b, expected all zero", dac_data, dac_dunf, dma_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) dac_rst = 1'b0;
      if (i == 5) dma_valid = 1'b0;
      dma = {$urandom, $urandom};
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL reset_mid beat %0d: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 i, dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
    dac_data_sel = 4'd11;
    for (int i = 0; i < 4; i++) begin
      step(ed, eu, er);
      vectors++;
      if (dac_data !== ed || dac_dunf !== eu || dma_ready !== er) begin
        miscompares++;
        $display("FAIL reset_restart beat %0d: data=%h dunf=%b ready=%b, expected data=%h dunf=%b ready=%b",
                 i, dac_data, dac_dunf, dma_ready, ed, eu, er);
      end
    end
  endtask

  initial begin
    int s;
    int fb;
    // Serial reference sequences from the all-ones seed
    s = 127;
    for (int i = 0; i < 127; i++) begin
      fb = ((s >> 6) ^ (s >> 5)) & 1;
      pn7_seq[i] = fb[0];
      s = ((s << 1) | fb) & 127;
    end
    s = 32767;
    for (int i = 0; i < 32767; i++) begin
      fb = ((s >> 14) ^ (s >> 13)) & 1;
      pn15_seq[i] = fb[0];
      s = ((s << 1) | fb) & 32767;
    end

    test_reset();
    test_pattern();
    test_dds();
    test_invalid();
    test_pn();
    test_dma();
    test_reset_mid();
    test_ramp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
